serial_pattern_source: RTL and testbench



---
 rtl/serial_pattern_source_pkg.sv | 10 +
 rtl/serial_pattern_source_bit_period_timer.sv | 34 +++
 rtl/serial_pattern_source.sv | 104 ++++++++++
 tb/tb_serial_pattern_source.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_source_pkg.sv
// Shared definitions for the serial pattern source: FSM state encoding.
package serial_pattern_source_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_pattern_source_bit_period_timer.sv
// Bit-period timer: counts 0..div while running and flags the last cycle of each period.
module bit_period_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             restart,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             period_end
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    assign period_end = run && (cnt == div_q);

    // An all-ones div wraps naturally through the equality check, giving 2^DIV_W cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (load) begin
            div_q <= div;
            cnt   <= '0;
        end else if (restart || period_end) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_source.sv
// Serial pattern source: captures a parallel pattern and plays it MSB-first on x.
module serial_pattern_source
    import serial_pattern_source_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [WIDTH-1:0]         data,
    input  logic [DIV_W-1:0]         div,
    output logic                     x,
    output logic                     bit_stb,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] shreg;
    logic             period_end;
    logic             load;
    logic             abort;

    assign load  = (state == IDLE) && start;
    assign abort = (state == SHIFT) && stop;

    bit_period_timer #(.DIV_W(DIV_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .restart    (abort),
        .run        (state == SHIFT),
        .div        (div),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pattern <= '0;
            shreg   <= '0;
            x       <= 1'b0;
            bit_stb <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
        end else begin
            bit_stb <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern <= data;
                        shreg   <= data;
                        x       <= data[WIDTH-1];
                        bit_idx <= '0;
                        bit_stb <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort wins over end-of-pattern; x keeps the bit it was showing.
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (period_end) begin
                        if (bit_idx != LAST_IDX) begin
                            shreg   <= shreg << 1;
                            x       <= shreg[WIDTH-2];
                            bit_idx <= bit_idx + 1'b1;
                            bit_stb <= 1'b1;
                        end else if (loop) begin
                            shreg   <= pattern;
                            x       <= pattern[WIDTH-1];
                            bit_idx <= '0;
                            bit_stb <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Directed bench for serial_pattern_source with WIDTH = 8.
module tb_serial_pattern_source;

    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic             loop;
    logic [WIDTH-1:0] data;
    logic [DIV_W-1:0] div;
    logic             x;
    logic             bit_stb;
    logic             busy;
    logic             done;
    logic [2:0]       bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    serial_pattern_source #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .data    (data),
        .div     (div),
        .x       (x),
        .bit_stb (bit_stb),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a one-cycle start; returns positioned in cycle 1.
    task automatic pulse_start(input logic [7:0] d, input logic [DIV_W-1:0] dv);
        data  = d;
        div   = dv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_checks++;
        if ({x, bit_stb, busy, done, bit_idx} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_held: got x=%b stb=%b busy=%b done=%b idx=%0d, want all 0",
                     x, bit_stb, busy, done, bit_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({x, bit_stb, busy, done, bit_idx} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release: got x=%b stb=%b busy=%b done=%b idx=%0d, want all 0",
                     x, bit_stb, busy, done, bit_idx);
        end
    endtask

    task automatic test_oneshot_div0();
        logic [7:0] pat = 8'b1010_0011;
        loop = 1'b0;
        pulse_start(pat, 24'd0);
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (x !== pat[8-c] || bit_stb !== 1'b1 || busy !== 1'b1 || done !== 1'b0
                || bit_idx !== 3'(c-1)) begin
                n_fail++;
                $display("FAIL div0_cycle%0d: got x=%b stb=%b busy=%b done=%b idx=%0d, want x=%b stb=1 busy=1 done=0 idx=%0d",
                         c, x, bit_stb, busy, done, bit_idx, pat[8-c], c-1);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bit_stb !== 1'b0 || x !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_done: got done=%b busy=%b stb=%b x=%b, want done=1 busy=0 stb=0 x=1",
                     done, busy, bit_stb, x);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_after_done: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_oneshot_div2();
        logic exp_stb;
        logic exp_x;
        loop = 1'b0;
        pulse_start(8'hF0, 24'd2);
        for (int c = 1; c <= 24; c++) begin
            exp_stb = ((c - 1) % 3 == 0);
            exp_x   = (c <= 12);
            n_checks++;
            if (x !== exp_x || bit_stb !== exp_stb || busy !== 1'b1 || done !== 1'b0
                || bit_idx !== 3'((c-1)/3)) begin
                n_fail++;
                $display("FAIL div2_cycle%0d: got x=%b stb=%b busy=%b done=%b idx=%0d, want x=%b stb=%b busy=1 done=0 idx=%0d",
                         c, x, bit_stb, busy, done, bit_idx, exp_x, exp_stb, (c-1)/3);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div2_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_loop();
        logic [7:0] pat = 8'h81;
        loop = 1'b1;
        pulse_start(pat, 24'd0);
        for (int c = 1; c <= 32; c++) begin
            n_checks++;
            if (x !== pat[7-((c-1)%8)] || bit_stb !== 1'b1 || done !== 1'b0 || busy !== 1'b1
                || bit_idx !== 3'((c-1)%8)) begin
                n_fail++;
                $display("FAIL loop_cycle%0d: got x=%b stb=%b busy=%b done=%b idx=%0d, want x=%b stb=1 busy=1 done=0 idx=%0d",
                         c, x, bit_stb, busy, done, bit_idx, pat[7-((c-1)%8)], (c-1)%8);
            end
            if (c == 3)  data = 8'h00;
            if (c == 25) loop = 1'b0;
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || x !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_exit_done: got done=%b busy=%b x=%b, want 1 0 1", done, busy, x);
        end
        tick();
    endtask

    task automatic test_stop();
        logic [7:0] pat = 8'hA3;
        loop = 1'b0;
        pulse_start(pat, 24'd1);
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (x !== pat[7-((c-1)/2)] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_pre_cycle%0d: got x=%b busy=%b, want x=%b busy=1",
                         c, x, busy, pat[7-((c-1)/2)]);
            end
            if (c == 5) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || x !== 1'b1 || bit_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_abort: got busy=%b done=%b x=%b stb=%b, want 0 0 1 0",
                     busy, done, x, bit_stb);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_no_done: got busy=%b done=%b, want 0 0", busy, done);
        end
        pulse_start(8'h55, 24'd1);
        n_checks++;
        if (bit_stb !== 1'b1 || x !== 1'b0 || busy !== 1'b1 || bit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL stop_restart: got stb=%b x=%b busy=%b idx=%0d, want 1 0 1 0",
                     bit_stb, x, busy, bit_idx);
        end
        repeat (16) tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_restart_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [7:0] pat = 8'hA3;
        loop = 1'b0;
        pulse_start(pat, 24'd0);
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (x !== pat[8-c] || bit_idx !== 3'(c-1) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ign_cycle%0d: got x=%b idx=%0d busy=%b, want x=%b idx=%0d busy=1",
                         c, x, bit_idx, busy, pat[8-c], c-1);
            end
            start = (c == 3);
            data  = (c == 3) ? 8'hFF : data;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_done: got done=%b, want 1", done);
        end
        start = 1'b1;
        data  = 8'hFF;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bit_stb !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_start_in_done: got busy=%b stb=%b done=%b, want 0 0 0",
                     busy, bit_stb, done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || bit_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_stays_idle: got busy=%b stb=%b, want 0 0", busy, bit_stb);
        end
    endtask

    task automatic test_reset_mid();
        loop = 1'b0;
        pulse_start(8'hFF, 24'd0);
        repeat (3) tick();
        n_checks++;
        if (x !== 1'b1 || busy !== 1'b1 || bit_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre: got x=%b busy=%b idx=%0d, want 1 1 3", x, busy, bit_idx);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({x, bit_stb, busy, done, bit_idx} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got x=%b stb=%b busy=%b done=%b idx=%0d, want all 0",
                     x, bit_stb, busy, done, bit_idx);
        end
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({x, bit_stb, busy, done} !== 4'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle%0d: got x=%b stb=%b busy=%b done=%b, want all 0",
                         c, x, bit_stb, busy, done);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        data    = '0;
        div     = '0;
        test_reset();
        test_oneshot_div0();
        test_oneshot_div2();
        test_loop();
        test_stop();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
